// File: rtl/io_stage_bypass_buffer.sv
// io_stage_bypass_buffer
//   Shift buffer of the last DEPTH register writes leaving the IO stage (slot 0 = youngest).
//   Resolves READ_PORTS operand reads against the buffer with per-byte strobe merging and
//   tracks a single outstanding load whose data is filled in later.
// Ports
//   clock_i, reset_i         clock, asynchronous active-high reset
//   flush_i                  invalidate every entry (drops same-cycle push and fill)
//   advance_i                shift buffer by one slot, slot 0 takes the push (or a bubble)
//   push_*_i                 instruction entering slot 0
//   fill_valid_i/fill_data_i returned load data for the pending entry
//   read_address_i           per-port register address
//   regfile_read_data_i      per-port architectural value
//   forward_data_o           per-port merged operand
//   forward_stall_o          per-port: a selected byte is still pending
//   load_pending_o           some valid entry awaits load data
//   protocol_error_o         sticky: a second pending load was pushed
module io_stage_bypass_buffer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned READ_PORTS     = 2,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 flush_i,
  input  logic                                 advance_i,
  input  logic                                 push_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]            push_write_register_i,
  input  logic [DATA_WIDTH/8-1:0]              push_write_strobe_i,
  input  logic [DATA_WIDTH-1:0]                push_write_data_i,
  input  logic                                 push_data_valid_i,
  input  logic                                 fill_valid_i,
  input  logic [DATA_WIDTH-1:0]                fill_data_i,
  input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] read_address_i,
  input  logic [READ_PORTS*DATA_WIDTH-1:0]     regfile_read_data_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]     forward_data_o,
  output logic [READ_PORTS-1:0]                forward_stall_o,
  output logic                                 load_pending_o,
  output logic                                 protocol_error_o
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;

  logic [DEPTH-1:0]                     valid_q, valid_d;
  logic [DEPTH-1:0]                     dvalid_q, dvalid_d;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DEPTH-1:0][Bytes-1:0]          strb_q, strb_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_q, data_d;
  logic                                 error_q, error_d;
  logic                                 fill_done;
  logic                                 byte_stall;
  logic [REG_ADDR_WIDTH-1:0]            addr;

  always_comb begin
    valid_d   = valid_q;
    dvalid_d  = dvalid_q;
    reg_d     = reg_q;
    strb_d    = strb_q;
    data_d    = data_q;
    error_d   = error_q;
    fill_done = 1'b0;
    if (flush_i) begin
      valid_d  = '0;
      dvalid_d = '1;
    end else begin
      if (advance_i) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          valid_d[i]  = valid_q[i-1];
          dvalid_d[i] = dvalid_q[i-1];
          reg_d[i]    = reg_q[i-1];
          strb_d[i]   = strb_q[i-1];
          data_d[i]   = data_q[i-1];
        end
        valid_d[0]  = push_valid_i;
        dvalid_d[0] = push_valid_i ? push_data_valid_i : 1'b1;
        reg_d[0]    = push_write_register_i;
        strb_d[0]   = push_write_strobe_i;
        data_d[0]   = push_write_data_i;
        // Error only if the older pending entry survives the shift.
        if (push_valid_i && !push_data_valid_i) begin
          for (int i = 1; i < DEPTH; i++) begin
            if (valid_d[i] && !dvalid_d[i]) error_d = 1'b1;
          end
        end
      end
      // Fill lands on the post-shift position; oldest pending entry is the outstanding load.
      if (fill_valid_i) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (!fill_done && valid_d[i] && !dvalid_d[i]) begin
            data_d[i]   = fill_data_i;
            dvalid_d[i] = 1'b1;
            fill_done   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q  <= '0;
      dvalid_q <= '1;
      reg_q    <= '0;
      strb_q   <= '0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      dvalid_q <= dvalid_d;
      reg_q    <= reg_d;
      strb_q   <= strb_d;
      data_q   <= data_d;
      error_q  <= error_d;
    end
  end

  // Oldest-to-youngest scan so the youngest matching slot wins each byte lane.
  always_comb begin
    forward_data_o  = regfile_read_data_i;
    forward_stall_o = '0;
    byte_stall      = 1'b0;
    addr            = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      addr = read_address_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      for (int b = 0; b < Bytes; b++) begin
        byte_stall = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
          if (valid_q[s] && (reg_q[s] == addr) && strb_q[s][b] && (addr != '0)) begin
            forward_data_o[p*DATA_WIDTH + b*8 +: 8] = data_q[s][b*8 +: 8];
            byte_stall = !dvalid_q[s];
          end
        end
        if (byte_stall) forward_stall_o[p] = 1'b1;
      end
    end
  end

  assign load_pending_o   = |(valid_q & ~dvalid_q);
  assign protocol_error_o = error_q;

endmodule
